// File: rtl/cam_capture_if.sv
// Handshake/bus bundle between the OV7670 capture sequencer and its
// neighbours: camera timing and system control in, datapath/buffer control out.
interface cam_capture_if #(
    parameter int ADDR_W = 15
);
    logic              Vsync;
    logic              Href;
    logic              Start;
    logic              Cont;
    logic              Abort;
    logic              Byte_sel;
    logic              Wr;
    logic [ADDR_W-1:0] Addr;
    logic              Busy;
    logic              Done;
    logic              Err;
    logic [6:0]        Line_cnt;

    modport master (
        output Vsync, Href, Start, Cont, Abort,
        input  Byte_sel, Wr, Addr, Busy, Done, Err, Line_cnt
    );

    modport slave (
        input  Vsync, Href, Start, Cont, Abort,
        output Byte_sel, Wr, Addr, Busy, Done, Err, Line_cnt
    );
endinterface

// File: rtl/cam_capture_ctrl.sv
// OV7670 capture sequencer: arms on Start, aligns to a Vsync fall, walks
// Href/Vsync timing and drives byte phase, write strobe and buffer address.
module cam_capture_ctrl #(
    parameter int H_PIX   = 160,
    parameter int V_LINES = 120,
    parameter int ADDR_W  = 15
) (
    input  logic          Pclk,
    input  logic          Rst_n,
    cam_capture_if.slave  bus
);
    localparam int             PW    = $clog2(H_PIX + 1);
    localparam logic [PW-1:0]  H_MAX = PW'(H_PIX);
    localparam logic [6:0]     V_MAX = 7'(V_LINES);
    localparam logic [6:0]     L_SAT = 7'd127;

    typedef enum logic [2:0] {IDLE, ARM, SYNC, CAPTURE, DONE} state_t;

    state_t            state;
    logic              vsync_d, href_d;
    logic              phase;
    logic              wr, busy, done, err;
    logic [ADDR_W-1:0] addr;
    logic [6:0]        line_cnt;
    logic [PW-1:0]     pix_cnt;

    logic       in_cap, vs_rise, vs_fall, hr_fall, store;
    logic [6:0] line_inc, lines_now;

    assign in_cap   = (state == CAPTURE);
    assign vs_rise  = bus.Vsync & ~vsync_d;
    assign vs_fall  = ~bus.Vsync & vsync_d;
    assign hr_fall  = ~bus.Href & href_d;
    // Second byte of a pixel, inside the stored window
    assign store    = in_cap & bus.Href & phase & (pix_cnt < H_MAX) & (line_cnt < V_MAX);
    assign line_inc = (line_cnt == L_SAT) ? line_cnt : line_cnt + 7'd1;
    // Frame check sees a line that ends on the same edge as Vsync rises
    assign lines_now = (in_cap & hr_fall) ? line_inc : line_cnt;

    assign bus.Byte_sel = in_cap & bus.Href & phase;
    assign bus.Wr       = wr;
    assign bus.Addr     = addr;
    assign bus.Busy     = busy;
    assign bus.Done     = done;
    assign bus.Err      = err;
    assign bus.Line_cnt = line_cnt;

    always_ff @(posedge Pclk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            vsync_d  <= 1'b0;
            href_d   <= 1'b0;
            phase    <= 1'b0;
            wr       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            addr     <= '0;
            line_cnt <= '0;
            pix_cnt  <= '0;
        end else begin
            vsync_d <= bus.Vsync;
            href_d  <= bus.Href;
            wr      <= 1'b0;
            done    <= 1'b0;
            phase   <= 1'b0;
            if (wr)
                addr <= addr + ADDR_W'(1);
            if (bus.Abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.Start) begin
                            state <= ARM;
                            busy  <= 1'b1;
                            err   <= 1'b0;
                        end
                    end
                    ARM: begin
                        if (bus.Vsync)
                            state <= SYNC;
                    end
                    SYNC: begin
                        if (vs_fall) begin
                            state    <= CAPTURE;
                            addr     <= '0;
                            line_cnt <= '0;
                            pix_cnt  <= '0;
                        end
                    end
                    CAPTURE: begin
                        phase <= bus.Href ? ~phase : 1'b0;
                        wr    <= store;
                        if (store)
                            pix_cnt <= pix_cnt + PW'(1);
                        // Odd byte count leaves phase set at the falling edge
                        if (hr_fall) begin
                            if (pix_cnt != H_MAX || phase)
                                err <= 1'b1;
                            pix_cnt  <= '0;
                            line_cnt <= line_inc;
                        end
                        if (vs_rise) begin
                            if (lines_now != V_MAX)
                                err <= 1'b1;
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= bus.Cont ? SYNC : IDLE;
                        busy  <= bus.Cont;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Scoreboard bench for cam_capture_ctrl on a reduced 4x3 geometry: stimulus
// queues expected writes/Done, a negedge monitor pops and compares.
module tb_cam_capture_ctrl;
    localparam int H  = 4;
    localparam int V  = 3;
    localparam int AW = 4;

    logic Pclk  = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Pclk = ~Pclk;

    cam_capture_if #(.ADDR_W(AW)) cif ();

    cam_capture_ctrl #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .Pclk  (Pclk),
        .Rst_n (Rst_n),
        .bus   (cif.slave)
    );

    typedef struct packed {
        logic       err;
        logic [6:0] lines;
    } done_t;

    int    n_chk  = 0;
    int    n_fail = 0;
    int    exp_addr[$];
    done_t exp_done[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Pclk);
        #1;
    endtask

    task automatic line(input int nb, input bit chk_bs);
        for (int b = 0; b < nb; b++) begin
            cif.Href = 1'b1;
            if (chk_bs) begin
                #1;
                check("byte_sel", cif.Byte_sel, b % 2);
            end
            tick();
        end
        cif.Href = 1'b0;
        tick();
        tick();
    endtask

    task automatic push_wr(input int n);
        for (int i = 0; i < n; i++)
            exp_addr.push_back(i);
    endtask

    task automatic frame(input int nlines, input int bad_line, input int bad_bytes,
                         input int exp_wr, input bit exp_d, input bit exp_err,
                         input int exp_lines, input bit chk_bs);
        done_t d;
        push_wr(exp_wr);
        if (exp_d) begin
            d.err   = exp_err;
            d.lines = 7'(exp_lines);
            exp_done.push_back(d);
        end
        cif.Vsync = 1'b0;
        tick();
        tick();
        for (int l = 0; l < nlines; l++)
            line((l == bad_line) ? bad_bytes : 2 * H, chk_bs && (l == 0));
        cif.Vsync = 1'b1;
        repeat (4) tick();
    endtask

    task automatic arm();
        cif.Start = 1'b1;
        tick();
        cif.Start = 1'b0;
        tick();
        tick();
    endtask

    always @(negedge Pclk) begin
        if (Rst_n && cif.Wr) begin
            if (exp_addr.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_wr: addr %0h, no write expected at %0t", cif.Addr, $time);
            end else begin
                check("wr_addr", cif.Addr, exp_addr.pop_front());
            end
        end
        if (Rst_n && cif.Done) begin
            if (exp_done.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: no Done expected at %0t", $time);
            end else begin
                done_t e;
                e = exp_done.pop_front();
                check("done_err", cif.Err, e.err);
                check("done_lines", cif.Line_cnt, e.lines);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cif.Vsync = 1'b1;
        cif.Href  = 1'b0;
        cif.Start = 1'b0;
        cif.Cont  = 1'b0;
        cif.Abort = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {cif.Byte_sel, cif.Wr, cif.Addr, cif.Busy, cif.Done,
                                cif.Err, cif.Line_cnt}, 0);
        Rst_n = 1'b1;
        tick();
        tick();

        // Nominal single frame
        arm();
        check("busy_armed", cif.Busy, 1);
        frame(3, -1, 0, 12, 1, 0, 3, 1);
        check("busy_after_done", cif.Busy, 0);
        check("err_nominal", cif.Err, 0);

        // Arm while a frame is already streaming
        cif.Vsync = 1'b0;
        tick();
        tick();
        line(2 * H, 0);
        cif.Start = 1'b1;
        tick();
        cif.Start = 1'b0;
        check("busy_mid_arm", cif.Busy, 1);
        line(2 * H, 0);
        line(2 * H, 0);
        cif.Vsync = 1'b1;
        tick();
        tick();
        frame(3, -1, 0, 12, 1, 0, 3, 0);
        check("busy_after_mid", cif.Busy, 0);

        // Short line (6 bytes) in line 1
        arm();
        frame(3, 1, 6, 11, 1, 1, 3, 0);
        check("err_short_sticky", cif.Err, 1);

        // One extra line
        arm();
        check("err_cleared_by_start", cif.Err, 0);
        frame(4, -1, 0, 12, 1, 1, 4, 0);

        // Continuous, three frames
        cif.Cont = 1'b1;
        arm();
        frame(3, -1, 0, 12, 1, 0, 3, 0);
        check("cont_busy_1", cif.Busy, 1);
        frame(3, -1, 0, 12, 1, 0, 3, 0);
        check("cont_busy_2", cif.Busy, 1);
        cif.Cont = 1'b0;
        frame(3, -1, 0, 12, 1, 0, 3, 0);
        check("cont_busy_end", cif.Busy, 0);

        // Line counter saturation
        arm();
        frame(130, -1, 0, 12, 1, 1, 127, 0);

        // Abort after a short first line
        arm();
        push_wr(3);
        cif.Vsync = 1'b0;
        tick();
        tick();
        line(6, 0);
        check("err_before_abort", cif.Err, 1);
        cif.Abort = 1'b1;
        tick();
        cif.Abort = 1'b0;
        check("abort_busy", cif.Busy, 0);
        check("abort_wr", cif.Wr, 0);
        check("abort_err_hold", cif.Err, 1);
        check("abort_addr_hold", cif.Addr, 3);
        line(2 * H, 0);
        line(2 * H, 0);
        cif.Vsync = 1'b1;
        repeat (4) tick();
        check("abort_stays_idle", cif.Busy, 0);

        // Start and Abort together
        cif.Start = 1'b1;
        cif.Abort = 1'b1;
        tick();
        cif.Start = 1'b0;
        cif.Abort = 1'b0;
        tick();
        check("start_abort_idle", cif.Busy, 0);
        check("start_abort_err", cif.Err, 1);
        frame(3, -1, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-line
        arm();
        push_wr(5);
        cif.Vsync = 1'b0;
        tick();
        tick();
        line(6, 0);
        for (int b = 0; b < 6; b++) begin
            cif.Href = 1'b1;
            tick();
        end
        #2;
        Rst_n = 1'b0;
        #1;
        check("reset_async", {cif.Byte_sel, cif.Wr, cif.Addr, cif.Busy, cif.Done,
                              cif.Err, cif.Line_cnt}, 0);
        tick();
        Rst_n    = 1'b1;
        cif.Href = 1'b0;
        tick();
        check("reset_idle", cif.Busy, 0);
        cif.Vsync = 1'b1;
        repeat (5) tick();

        check("wr_queue_empty", exp_addr.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
